// File: rtl/bcd_seg7_scanner.sv
// -----------------------------------------------------------------------------
// bcd_seg7_scanner
//
// Four-digit, time-multiplexed seven-segment driver for a common-anode display.
// Takes the packed BCD digits from the up/down counter chain and drives one
// digit slot at a time. Each slot lasts 2^DIV_W clock cycles. A snapshot of all
// four digits is taken at the start of every scan frame, so a frame never mixes
// digits from two different counts.
//
// Ports
//   clk          system clock, all state changes on posedge
//   reset        asynchronous, active-high reset
//   en           scan enable; low = display dark, prescaler/digit index frozen
//   bcd[15:0]    packed digits, [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   dp_in[3:0]   decimal point request per digit, active-high
//   blank_lz     1 = blank leading zeros on digits 3..1
//   seg_n[6:0]   segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n         decimal point, active-low, registered
//   an_n[3:0]    digit anode selects, active-low, one-hot-zero, registered
//   frame_start  one-cycle pulse in the cycle the snapshot is captured
// -----------------------------------------------------------------------------
module bcd_seg7_scanner #(
  parameter int DIV_W         = 16,
  // Records how blank_lz is normally strapped on the board. The live control
  // is always the blank_lz input.
  parameter int BLANK_DEFAULT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  if (DIV_W < 1 || BLANK_DEFAULT < 0 || BLANK_DEFAULT > 1) begin : g_bad_params
    $error("bcd_seg7_scanner: DIV_W must be >= 1 and BLANK_DEFAULT must be 0 or 1");
  end

  localparam logic [DIV_W-1:0] P_MAX    = {DIV_W{1'b1}};
  localparam logic [6:0]       SEG_DARK = 7'b1111111;
  localparam logic [6:0]       SEG_DASH = 7'b0111111;

  // Segment pattern for one digit code; codes 10..15 show a dash.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [DIV_W-1:0] p_q, p_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      bcd_s_q, bcd_s_d;
  logic [3:0]       dp_s_q, dp_s_d;

  // Output registers
  logic [6:0]       seg_n_q, seg_n_d;
  logic             dp_n_q, dp_n_d;
  logic [3:0]       an_n_q, an_n_d;
  logic             frame_start_q, frame_start_d;

  // Per-cycle decode
  logic             capture;
  logic [15:0]      cur_bcd;
  logic [3:0]       cur_dp;
  logic [3:0]       cur_digit;
  logic [3:0]       zero_from;   // zero_from[k]: digits k..3 are all zero
  logic             cur_blank;

  // Start of frame: slot 0, first prescaler count, scanning enabled.
  assign capture = en && (p_q == '0) && (idx_q == 2'd0);

  // In the capture cycle the snapshot register still holds the old frame, so
  // the digit is taken straight from the inputs that are being captured.
  assign cur_bcd   = capture ? bcd   : bcd_s_q;
  assign cur_dp    = capture ? dp_in : dp_s_q;
  assign cur_digit = cur_bcd[{idx_q, 2'b00} +: 4];

  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    zero_from    = '0;
    zero_from[3] = (cur_bcd[15:12] == 4'd0);
    for (int k = 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (cur_bcd[k*4 +: 4] == 4'd0);
    end
  end

  // Digit0 is never blanked; a digit with its decimal point lit always shows.
  // Invalid codes are nonzero, so they stop the zero run naturally.
  assign cur_blank = blank_lz && (idx_q != 2'd0) && zero_from[idx_q] && !cur_dp[idx_q];

  // Next-state logic
  always_comb begin
    p_d           = p_q;
    idx_d         = idx_q;
    bcd_s_d       = bcd_s_q;
    dp_s_d        = dp_s_q;
    seg_n_d       = SEG_DARK;
    dp_n_d        = 1'b1;
    an_n_d        = 4'b1111;
    frame_start_d = 1'b0;

    if (en) begin
      p_d = p_q + 1'b1;
      if (p_q == P_MAX) begin
        idx_d = idx_q + 2'd1;
      end

      if (capture) begin
        bcd_s_d = bcd;
        dp_s_d  = dp_in;
      end

      // Anode stays driven when a leading zero is blanked; only segments go dark.
      an_n_d        = ~(4'b0001 << idx_q);
      seg_n_d       = cur_blank ? SEG_DARK : glyph(cur_digit);
      dp_n_d        = ~cur_dp[idx_q];
      frame_start_d = capture;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q           <= '0;
      idx_q         <= 2'd0;
      bcd_s_q       <= 16'h0000;
      dp_s_q        <= 4'b0000;
      seg_n_q       <= SEG_DARK;
      dp_n_q        <= 1'b1;
      an_n_q        <= 4'b1111;
      frame_start_q <= 1'b0;
    end else begin
      p_q           <= p_d;
      idx_q         <= idx_d;
      bcd_s_q       <= bcd_s_d;
      dp_s_q        <= dp_s_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg7_scanner
//
// Self-checking bench for bcd_seg7_scanner with a 4-cycle digit slot
// (DIV_W = 2). A behavioural model predicts every registered output word as
// each clock's stimulus is applied and queues it; each scenario task pops the
// prediction after the edge and compares it with the DUT, and adds literal
// checks for the glyphs and timing points the scenario is about.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_seg7_scanner;

  localparam int DIV_W = 2;
  localparam int SLOT  = 1 << DIV_W;
  localparam int FRAME = 4 * SLOT;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, GDASH = 7'b0111111, GOFF = 7'b1111111;

  localparam logic [3:0] AN_WALK [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] bcd;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_start;

  obs_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Model state: values the next clock edge will act on.
  logic [DIV_W-1:0] m_p;
  logic [1:0]       m_idx;
  logic [15:0]      m_bcd_s;
  logic [3:0]       m_dp_s;

  always #5 clk = ~clk;

  bcd_seg7_scanner #(.DIV_W(DIV_W), .BLANK_DEFAULT(1)) dut (
    .clk(clk), .reset(reset), .en(en), .bcd(bcd), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame_start(frame_start)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'd0: return G0;  4'd1: return G1;  4'd2: return G2;  4'd3: return G3;
      4'd4: return G4;  4'd5: return G5;  4'd6: return G6;  4'd7: return G7;
      4'd8: return G8;  4'd9: return G9;
      default: return GDASH;
    endcase
  endfunction

  // One step of a BCD down-counter chain: 9 -> 0 per digit, borrowing upward.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < 4; k++) begin
      if (r[k*4 +: 4] == 4'd0) begin
        r[k*4 +: 4] = 4'd9;
      end else begin
        r[k*4 +: 4] = r[k*4 +: 4] - 4'd1;
        break;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_p     = '0;
    m_idx   = 2'd0;
    m_bcd_s = 16'h0000;
    m_dp_s  = 4'b0000;
  endtask

  // Predict the output word for the coming edge from the current inputs,
  // queue it, then advance one clock and settle 1 ns past the edge.
  task automatic tick();
    obs_t        e;
    logic [15:0] d_all;
    logic [3:0]  dps;
    logic        blank;
    logic        cap;
    cap = en && (m_p == 0) && (m_idx == 2'd0);
    e.an = 4'b1111; e.seg = GOFF; e.dp = 1'b1; e.fs = 1'b0;
    if (en) begin
      d_all = cap ? bcd : m_bcd_s;
      dps   = cap ? dp_in : m_dp_s;
      blank = 1'b0;
      if (blank_lz && m_idx != 2'd0 && !dps[m_idx]) begin
        blank = 1'b1;
        for (int k = int'(m_idx); k < 4; k++)
          if (d_all[k*4 +: 4] != 4'd0) blank = 1'b0;
      end
      e.an[m_idx] = 1'b0;
      e.seg = blank ? GOFF : ref_glyph(d_all[int'(m_idx)*4 +: 4]);
      e.dp  = ~dps[m_idx];
      e.fs  = cap;
      if (cap) begin
        m_bcd_s = bcd;
        m_dp_s  = dp_in;
      end
      if (m_p == DIV_W'(SLOT - 1)) m_idx = m_idx + 2'd1;
      m_p = m_p + 1'b1;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    reset = 1'b1; en = 1'b0; bcd = 16'h0000; dp_in = 4'b0000; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    got = {an_n, seg_n, dp_n, frame_start};
    if (got !== {4'b1111, GOFF, 1'b1, 1'b0})
      $display("FAIL reset_dark: got {an,seg,dp,fs}=%b want %b", got, {4'b1111, GOFF, 1'b1, 1'b0});
    else pass_cnt++;
    reset = 1'b0;
    model_reset();
    en  = 1'b1;
    bcd = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want) $display("FAIL pre_reset_sb[%0d]: got %b want %b", i, got, want);
      else pass_cnt++;
    end
    // Asynchronous reset in the middle of slot 1, between clock edges.
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    got = {an_n, seg_n, dp_n, frame_start};
    if (got !== {4'b1111, GOFF, 1'b1, 1'b0})
      $display("FAIL async_reset_dark: got %b want %b", got, {4'b1111, GOFF, 1'b1, 1'b0});
    else pass_cnt++;
    model_reset();
    #1 reset = 1'b0;
  endtask

  task automatic test_scan();
    obs_t             got, want;
    logic [6:0] seg_tab [4];
    seg_tab = '{G4, G3, G2, G1};
    for (int i = 0; i < FRAME; i++) begin
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want) $display("FAIL scan_sb[%0d]: got %b want %b", i, got, want);
      else pass_cnt++;
      if (i % SLOT == 0) begin
        total_cnt++;
        if (an_n !== AN_WALK[i/SLOT] || seg_n !== seg_tab[i/SLOT] || frame_start !== (i == 0))
          $display("FAIL scan_digit[%0d]: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b",
                   i/SLOT, an_n, seg_n, frame_start, AN_WALK[i/SLOT], seg_tab[i/SLOT], i == 0);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_snapshot();
    obs_t       got, want;
    logic [6:0] tail_tab [2];
    logic [6:0] next_tab [4];
    tail_tab = '{G2, G1};
    next_tab = '{G8, G7, G6, G5};
    for (int i = 0; i < FRAME + FRAME / 2; i++) begin
      if (i == FRAME / 2) bcd = 16'h5678;   // lands while idx == 2
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want) $display("FAIL snapshot_sb[%0d]: got %b want %b", i, got, want);
      else pass_cnt++;
      if (i >= FRAME / 2 && i < FRAME && i % SLOT == 0) begin
        total_cnt++;
        if (seg_n !== tail_tab[(i - FRAME/2) / SLOT])
          $display("FAIL snapshot_hold[%0d]: got seg=%b want %b", i, seg_n, tail_tab[(i - FRAME/2) / SLOT]);
        else pass_cnt++;
      end
      if (i >= FRAME && (i - FRAME) % SLOT == 0) begin
        total_cnt++;
        if (seg_n !== next_tab[(i - FRAME) / SLOT])
          $display("FAIL snapshot_next[%0d]: got seg=%b want %b", i, seg_n, next_tab[(i - FRAME) / SLOT]);
        else pass_cnt++;
      end
    end
    // The prefix above was FRAME/2 cycles; finish the frame to realign.
    for (int i = 0; i < FRAME / 2; i++) begin
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want) $display("FAIL snapshot_tail_sb[%0d]: got %b want %b", i, got, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_blanking();
    obs_t        got, want;
    logic [15:0] bcd_tab [3];
    logic [3:0]  dp_tab  [3];
    logic [6:0]  seg_tab [3][4];
    bcd_tab = '{16'h0070, 16'h0000, 16'h0000};
    dp_tab  = '{4'b0000, 4'b0000, 4'b0100};
    seg_tab = '{'{G0, G7, GOFF, GOFF}, '{G0, GOFF, GOFF, GOFF}, '{G0, GOFF, G0, GOFF}};
    blank_lz = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bcd   = bcd_tab[c];
      dp_in = dp_tab[c];
      for (int i = 0; i < FRAME; i++) begin
        tick();
        want = exp_q.pop_front();
        got  = {an_n, seg_n, dp_n, frame_start};
        total_cnt++;
        if (got !== want) $display("FAIL blank_sb[%0d][%0d]: got %b want %b", c, i, got, want);
        else pass_cnt++;
        // Digit 1 of the dp case follows the zero-run rule; the model covers it.
        if (i % SLOT == 1 && !(c == 2 && i / SLOT == 1)) begin
          total_cnt++;
          if (an_n !== AN_WALK[i/SLOT] || seg_n !== seg_tab[c][i/SLOT] ||
              dp_n !== !dp_tab[c][i/SLOT])
            $display("FAIL blank_digit[%0d][%0d]: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                     c, i/SLOT, an_n, seg_n, dp_n, AN_WALK[i/SLOT], seg_tab[c][i/SLOT], !dp_tab[c][i/SLOT]);
          else pass_cnt++;
        end
      end
    end
    dp_in = 4'b0000;
  endtask

  task automatic test_invalid();
    obs_t       got, want;
    logic [6:0] seg_tab [4];
    seg_tab = '{G0, GDASH, G9, GDASH};
    bcd = 16'hA9F0;
    for (int c = 0; c < 2; c++) begin
      blank_lz = (c == 1);
      for (int i = 0; i < FRAME; i++) begin
        tick();
        want = exp_q.pop_front();
        got  = {an_n, seg_n, dp_n, frame_start};
        total_cnt++;
        if (got !== want) $display("FAIL invalid_sb[%0d][%0d]: got %b want %b", c, i, got, want);
        else pass_cnt++;
        if (i % SLOT == 2) begin
          total_cnt++;
          if (seg_n !== seg_tab[i/SLOT])
            $display("FAIL invalid_digit[%0d][%0d]: got seg=%b want %b", c, i/SLOT, seg_n, seg_tab[i/SLOT]);
          else pass_cnt++;
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_enable();
    obs_t got, want;
    int   n;
    bcd = 16'h1234;
    n = 0;
    while (!(m_idx == 2'd1 && m_p == DIV_W'(2)) && n < FRAME) begin
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want) $display("FAIL enable_pre_sb[%0d]: got %b want %b", n, got, want);
      else pass_cnt++;
      n++;
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want || got !== {4'b1111, GOFF, 1'b1, 1'b0})
        $display("FAIL enable_dark[%0d]: got %b want %b", i, got, {4'b1111, GOFF, 1'b1, 1'b0});
      else pass_cnt++;
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want || an_n !== ((i < 2) ? 4'b1101 : 4'b1011) || seg_n !== ((i < 2) ? G3 : G2))
        $display("FAIL enable_resume[%0d]: got an=%b seg=%b want an=%b seg=%b",
                 i, an_n, seg_n, (i < 2) ? 4'b1101 : 4'b1011, (i < 2) ? G3 : G2);
      else pass_cnt++;
    end
    n = 0;
    while (!(m_idx == 2'd0 && m_p == '0) && n < FRAME) begin
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want) $display("FAIL enable_post_sb[%0d]: got %b want %b", n, got, want);
      else pass_cnt++;
      n++;
    end
  endtask

  task automatic test_counter();
    obs_t        got, want;
    logic [15:0] cnt;
    logic [15:0] drv;
    logic [15:0] snap;
    blank_lz = 1'b0;
    dp_in    = 4'b0000;
    cnt      = 16'h0103;
    snap     = 16'h0000;
    bcd      = cnt;
    for (int i = 0; i < 3 * FRAME; i++) begin
      drv = bcd;
      tick();
      want = exp_q.pop_front();
      got  = {an_n, seg_n, dp_n, frame_start};
      total_cnt++;
      if (got !== want) $display("FAIL counter_sb[%0d]: got %b want %b", i, got, want);
      else pass_cnt++;
      if (i % FRAME == 0) snap = drv;
      total_cnt++;
      if (frame_start !== (i % FRAME == 0) ||
          seg_n !== ref_glyph(snap[((i % FRAME) / SLOT) * 4 +: 4]))
        $display("FAIL counter_frame[%0d]: got seg=%b fs=%b want seg=%b fs=%b (snapshot %h)",
                 i, seg_n, frame_start, ref_glyph(snap[((i % FRAME) / SLOT) * 4 +: 4]),
                 i % FRAME == 0, snap);
      else pass_cnt++;
      cnt = bcd_dec(cnt);
      bcd = cnt;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blanking();
    test_invalid();
    test_enable();
    test_counter();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_scanner.md
Name: bcd_seg7_scanner

Overview:
- Four-digit time-multiplexed seven-segment driver; consumes the packed 4-bit BCD values produced by the team's BCD up/down counter chain.
- Sits between the counter outputs and the board's common-anode display.
- Captures a coherent snapshot of all four digits once per scan frame, so the display never shows a half-updated count.
- Supports leading-zero blanking, per-digit decimal point, and a dash glyph for invalid codes.

Parameters:
DIV_W, 16, width of refresh prescaler; one digit slot = 2^DIV_W clk cycles
BLANK_DEFAULT, 1, value of leading-zero blanking enable when blank_lz is tied high (documentation only; blank_lz is the live control)

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-high reset
en  input  1  scan enable; low = display dark, prescaler and digit index frozen
bcd  input  16  packed digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3
dp_in  input  4  decimal point request per digit, bit i = digit i, active-high
blank_lz  input  1  1 = blank leading zeros on digits 3..1
seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
dp_n  output  1  decimal point, active-low, registered
an_n  output  4  digit anode selects, active-low, one-hot-zero, registered
frame_start  output  1  one-cycle pulse when snapshot is captured, registered

Behaviour:
- Reset (async, any time, including mid-frame):
  - prescaler=0, digit index=0, snapshot bcd_s=0, dp_s=0.
  - Outputs: an_n=4'b1111, seg_n=7'b1111111, dp_n=1, frame_start=0.
- State:
  - prescaler p[DIV_W-1:0].
  - digit index idx[1:0], sequence 0,1,2,3,0...
  - snapshot registers bcd_s[15:0], dp_s[3:0].
- Each posedge with en=1:
  - p increments, wrapping 2^DIV_W-1 -> 0.
  - When p wraps, idx increments mod 4.
- Snapshot: on a posedge with en=1, p==0 and idx==0 (start of frame), load bcd_s<=bcd and dp_s<=dp_in; frame_start<=1 that cycle, else 0.
  - The first enabled cycle after reset is a frame start.
  - bcd/dp_in changes elsewhere in the frame are invisible until the next frame.
- Output registers, updated every posedge with en=1 from current idx and the digit code d:
  - d = bcd_s, or bcd itself in the capture cycle, so display and snapshot agree.
  - an_n: bit idx low, others high.
  - seg_n from d: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - d in 10..15: dash, 0111111.
  - dp_n = ~dp for that digit.
- Latency: one clk from idx/snapshot change to outputs.
- Leading-zero blanking (blank_lz=1):
  - Digit k (k=3..1) is blanked when it and all higher digits equal 0: seg_n=1111111, anode still driven.
  - Digit0 is never blanked, so 0000 shows "0".
  - A digit with its dp set is never blanked.
  - An invalid code counts as nonzero.
- en=0:
  - Outputs forced dark (an_n=1111, seg_n=1111111, dp_n=1) on the next posedge.
  - p, idx and snapshot hold; frame_start=0.
  - Re-enable resumes the same slot at the held p.
- Combinational paths: none from inputs to outputs; all outputs are flops.
- Implementation fits in 120-250 lines of RTL.

Test Plan:
1. DIV_W=2, reset pulse mid-frame -> outputs dark that cycle. After release with en=1, bcd=16'h1234, blank_lz=0: frame_start pulses on the first cycle. an_n walks 1110,1101,1011,0111 every 4 clks. seg_n shows 4,3,2,1 (0011001, 0110000, 0100100, 1111001).
2. bcd changes from 16'h1234 to 16'h5678 while idx=2 -> digits 2 and 3 still show 2 and 1. The next frame shows 8,7,6,5.
3. blank_lz=1, bcd=16'h0070, dp_in=4'b0000 -> digit3 and digit2 blank, digit1 shows 7, digit0 shows 0. With bcd=16'h0000, only digit0 lit ("0"). With dp_in=4'b0100, digit2 shows "0" with dp_n=0.
4. bcd=16'hA9F0 -> digit3 dash (0111111), digit2 "9", digit1 dash, digit0 "0". With blank_lz=1, no digit is blanked.
5. en deasserted at idx=1, p=2 for 10 clks -> dark on the next edge; p and idx hold. After re-enable, digit1 completes its remaining 2 clks before idx=2.
6. Run under Lab counter stimulus (count 9 -> 0 down, carry into the next digit) for 3 frames -> each frame_start snapshot matches the counter value at that edge; no mixed-digit frames.
